pc_gen: RTL and testbench

//  Parametrised program-counter generator for the fetch stage.
//  - Produces the fetch address and drives a valid/ready request to instruction memory.
//  - Applies redirects: flush/trap, JALR, JAL, branch.
//  - Buffers one redirect that arrives while a fetch is back-pressured.
//  - Detects misaligned targets and halts fetch until a flush.

---
 rtl/pc_gen.sv | 112 +++++++++++
 tb/tb_pc_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential stepping, prioritised redirects,
// one-deep redirect buffer under back-pressure, and misaligned-target halt.
module pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     STEP       = 4,
  parameter int unsigned     ALIGN_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            jal_en_i,
  input  logic            jalr_en_i,
  input  logic            br_en_i,
  input  logic [XLEN-1:0] jmp_to_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            if_kill_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] badaddr_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_LOG2) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state;
  logic            pend_vld;
  logic [XLEN-1:0] pend_pc;

  logic            redir_c;
  logic [XLEN-1:0] tgt_c;
  logic            mis_c;
  logic            bp_c;
  logic            hs_c;

  assign if_valid_o = (state == ST_FETCH) && !stall_i;
  assign bp_c       = if_valid_o && !if_ready_i;
  assign hs_c       = if_valid_o && if_ready_i;

  // Redirect arbitration: flush > jalr > jal > br; only flush is honoured in HALT.
  always_comb begin
    redir_c = 1'b0;
    tgt_c   = '0;
    if (flush_i) begin
      redir_c = 1'b1;
      tgt_c   = flush_pc_i & ~ALIGN_MASK;
    end else if (state != ST_HALT) begin
      if (jalr_en_i) begin
        redir_c = 1'b1;
        tgt_c   = jmp_to_i & ~XLEN'(1);
      end else if (jal_en_i || br_en_i) begin
        redir_c = 1'b1;
        tgt_c   = pc_o + jmp_to_i;
      end
    end
  end

  assign mis_c = redir_c && ((tgt_c & ALIGN_MASK) != '0);

  // The accepted instruction is stale only when a buffered redirect is about to replace pc_o.
  assign if_kill_o = hs_c && pend_vld && !redir_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc_o       <= RESET_PC;
      pend_vld   <= 1'b0;
      pend_pc    <= '0;
      misalign_o <= 1'b0;
      badaddr_o  <= '0;
    end else begin
      misalign_o <= 1'b0;
      if (state == ST_IDLE) begin
        state <= ST_FETCH;
      end
      if (redir_c) begin
        if (mis_c) begin
          state      <= ST_HALT;
          misalign_o <= 1'b1;
          badaddr_o  <= tgt_c;
          pend_vld   <= 1'b0;
        end else if (bp_c) begin
          // pc_o must stay stable while the request is outstanding.
          pend_vld <= 1'b1;
          pend_pc  <= tgt_c;
        end else begin
          pc_o     <= tgt_c;
          pend_vld <= 1'b0;
          if (state == ST_HALT) begin
            state <= ST_FETCH;
          end
        end
      end else if (hs_c) begin
        if (pend_vld) begin
          pc_o     <= pend_pc;
          pend_vld <= 1'b0;
        end else begin
          pc_o <= pc_o + XLEN'(STEP);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural fetch model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, jal_en_i, jalr_en_i, br_en_i, if_ready_i;
  logic [31:0] flush_pc_i, jmp_to_i;
  logic        if_valid_o, if_kill_o, misalign_o;
  logic [31:0] pc_o, badaddr_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pc_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .jal_en_i   (jal_en_i),
    .jalr_en_i  (jalr_en_i),
    .br_en_i    (br_en_i),
    .jmp_to_i   (jmp_to_i),
    .if_valid_o (if_valid_o),
    .if_ready_i (if_ready_i),
    .pc_o       (pc_o),
    .if_kill_o  (if_kill_o),
    .misalign_o (misalign_o),
    .badaddr_o  (badaddr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: bubble counter since reset, halt flag, pending queue.
  bit          m_live = 1'b0;
  bit          m_halted;
  bit          m_mis;
  int unsigned m_since;
  logic [31:0] m_pc, m_bad;
  logic [31:0] m_pend[$];

  logic        seen_valid, seen_kill;
  logic [31:0] seen_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a);
    return (a % 4) != 0;
  endfunction

  // What the model says the redirect this cycle is, if any.
  task automatic model_redirect(output bit have, output logic [31:0] tgt);
    have = 1'b0;
    tgt  = '0;
    if (flush_i) begin
      have = 1'b1;
      tgt  = flush_pc_i - (flush_pc_i % 4);
    end else if (!m_halted) begin
      if (jalr_en_i) begin
        have = 1'b1;
        tgt  = jmp_to_i - (jmp_to_i % 2);
      end else if (jal_en_i || br_en_i) begin
        have = 1'b1;
        tgt  = m_pc + jmp_to_i;
      end
    end
  endtask

  // One clock: compare outputs for the current inputs, then advance the model at the edge.
  task automatic step();
    bit          have, exp_valid, accept;
    logic [31:0] tgt;
    #1;
    seen_valid = if_valid_o;
    seen_kill  = if_kill_o;
    seen_pc    = pc_o;
    model_redirect(have, tgt);
    exp_valid = !m_halted && (m_since >= 1) && !stall_i;
    accept    = exp_valid && if_ready_i;
    if (m_live) begin
      chk("pc", pc_o, m_pc);
      chk("valid", 32'(if_valid_o), 32'(exp_valid));
      chk("kill", 32'(if_kill_o), 32'(accept && (m_pend.size() > 0) && !have));
      chk("misalign", 32'(misalign_o), 32'(m_mis));
      chk("badaddr", badaddr_o, m_bad);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_live   = 1'b1;
      m_halted = 1'b0;
      m_mis    = 1'b0;
      m_since  = 0;
      m_pc     = 32'h0;
      m_bad    = 32'h0;
      m_pend.delete();
    end else begin
      m_mis = 1'b0;
      if (have) begin
        if (is_mis(tgt)) begin
          m_halted = 1'b1;
          m_mis    = 1'b1;
          m_bad    = tgt;
          m_pend.delete();
        end else if (exp_valid && !if_ready_i) begin
          m_pend.delete();
          m_pend.push_back(tgt);
        end else begin
          m_pc     = tgt;
          m_halted = 1'b0;
          m_pend.delete();
        end
      end else if (accept) begin
        if (m_pend.size() > 0) m_pc = m_pend.pop_front();
        else m_pc = m_pc + 32'd4;
      end
      if (m_since < 2) m_since++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    stall_i = 1'b0; flush_i = 1'b0; jal_en_i = 1'b0; jalr_en_i = 1'b0; br_en_i = 1'b0;
    flush_pc_i = '0; jmp_to_i = '0;
  endtask

  task automatic flush_to(input logic [31:0] a);
    quiet(); if_ready_i = 1'b1; flush_i = 1'b1; flush_pc_i = a;
    step();
    quiet();
  endtask

  initial begin
    int r;
    rst_n = 1'b0; if_ready_i = 1'b1;
    quiet();
    @(negedge clk);

    // Reset and the single post-reset bubble, then sequential stepping.
    step();
    step();
    chk("t1_rst_pc", pc_o, 32'h0);
    chk("t1_rst_valid", 32'(seen_valid), 32'h0);
    chk("t1_rst_badaddr", badaddr_o, 32'h0);
    rst_n = 1'b1;
    step();
    chk("t1_bubble", 32'(seen_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_seq_pc", seen_pc, 32'(4 * k));
      chk("t1_seq_valid", 32'(seen_valid), 32'h1);
    end

    // Taken branch with a negative offset.
    flush_to(32'h100);
    br_en_i = 1'b1; jmp_to_i = 32'hFFFF_FFF0;
    step();
    chk("t2_kill", 32'(seen_kill), 32'h0);
    quiet();
    chk("t2_pc", pc_o, 32'h0000_00F0);

    // JAL under back-pressure is buffered and applied at accept with a kill.
    flush_to(32'h20);
    if_ready_i = 1'b0; jal_en_i = 1'b1; jmp_to_i = 32'h40;
    step();
    quiet();
    step();
    chk("t3_hold_pc", seen_pc, 32'h20);
    step();
    chk("t3_hold_pc2", seen_pc, 32'h20);
    if_ready_i = 1'b1;
    step();
    chk("t3_accept_kill", 32'(seen_kill), 32'h1);
    chk("t3_new_pc", pc_o, 32'h60);

    // Flush beats JALR in the same cycle.
    flush_i = 1'b1; flush_pc_i = 32'h80; jalr_en_i = 1'b1; jmp_to_i = 32'h300;
    step();
    quiet();
    chk("t4_pc", pc_o, 32'h80);

    // Misaligned JALR halts fetch until a flush.
    flush_to(32'h10);
    jalr_en_i = 1'b1; jmp_to_i = 32'h203;
    step();
    quiet();
    chk("t5_mis", 32'(misalign_o), 32'h1);
    chk("t5_bad", badaddr_o, 32'h202);
    step();
    chk("t5_halt_valid", 32'(seen_valid), 32'h0);
    chk("t5_mis_pulse", 32'(misalign_o), 32'h0);
    jal_en_i = 1'b1; jmp_to_i = 32'h40;
    step();
    quiet();
    chk("t5_ignored_pc", pc_o, 32'h10);
    flush_to(32'h1000);
    step();
    chk("t5_resume_pc", seen_pc, 32'h1000);
    chk("t5_resume_valid", 32'(seen_valid), 32'h1);

    // Wrap-around, then reset while a redirect is pending.
    flush_to(32'hFFFF_FFFC);
    step();
    chk("t6_wrap", pc_o, 32'h0);
    if_ready_i = 1'b0; jal_en_i = 1'b1; jmp_to_i = 32'h100;
    step();
    quiet();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; if_ready_i = 1'b1;
    step();
    chk("t6_bubble", 32'(seen_valid), 32'h0);
    step();
    chk("t6_pc_after_rst", seen_pc, 32'h0);
    chk("t6_no_kill", 32'(seen_kill), 32'h0);
    chk("t6_next", pc_o, 32'h4);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      quiet();
      rst_n      = ($urandom_range(0, 299) != 0);
      stall_i    = ($urandom_range(0, 6) == 0);
      if_ready_i = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 99));
      flush_i    = (r < 4) || (m_halted && r < 30);
      jalr_en_i  = (r >= 4 && r < 10) || ($urandom_range(0, 19) == 0);
      jal_en_i   = (r >= 10 && r < 18) || ($urandom_range(0, 19) == 0);
      br_en_i    = (r >= 18 && r < 26) || ($urandom_range(0, 19) == 0);
      flush_pc_i = $urandom;
      jmp_to_i   = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
